// File: rtl/mt_sequencer_pkg.sv
// Shared types and helpers for the machine-cycle / T-state sequencer.
// Holds default depths, the request priority encoding and one-hot helpers.
package seq_pkg;

  localparam int unsigned SEQ_M_CYCLES = 6;
  localparam int unsigned SEQ_T_STATES = 6;

  typedef enum logic [1:0] {
    SEQ_HOLD,
    SEQ_M1,
    SEQ_NEXTM,
    SEQ_STEPT
  } seq_op_t;

  function automatic logic [63:0] idx2oh(input int unsigned i);
    return 64'd1 << i;
  endfunction

  function automatic int unsigned oh2idx(input logic [63:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/mt_sequencer_onehot_counter.sv
// Saturating counter kept as a binary index plus a matching one-hot vector.
// clear beats step; step at the top value holds the count.
module onehot_counter
  import seq_pkg::*;
#(
  parameter int unsigned N = 6,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         step,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         at_max
);

  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] oh_q, oh_d;

  assign at_max = (idx_q == W'(N - 1));

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (step && !at_max) begin
      idx_d = idx_q + 1'b1;
    end
    oh_d = N'(idx2oh(32'(idx_d)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      oh_q  <= N'(1);
    end else begin
      idx_q <= idx_d;
      oh_q  <= oh_d;
    end
  end

  assign onehot = oh_q;
  assign idx    = idx_q;

endmodule

// File: rtl/mt_sequencer.sv
// M-cycle / T-state sequencer: request priority decode and sticky error.
// Both counters freeze while hold_clk is high.
module mt_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned M_CYCLES = SEQ_M_CYCLES,
  parameter int unsigned T_STATES = SEQ_T_STATES,
  parameter int unsigned MW       = $clog2(M_CYCLES),
  parameter int unsigned TW       = $clog2(T_STATES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold_clk,
  input  logic                nextM,
  input  logic                setM1,
  input  logic                setM1_cond,
  input  logic                cond_true,
  output logic [M_CYCLES-1:0] m_onehot,
  output logic [T_STATES-1:0] t_onehot,
  output logic [MW-1:0]       m_idx,
  output logic [TW-1:0]       t_idx,
  output logic                last_t,
  output logic                seq_err
);

  seq_op_t op;
  logic    m_max, t_max;
  logic    m_clr, m_step;
  logic    t_clr, t_step;
  logic    err_q, err_d;

  always_comb begin
    op = SEQ_STEPT;
    priority case (1'b1)
      hold_clk:                         op = SEQ_HOLD;
      setM1 | (setM1_cond & ~cond_true): op = SEQ_M1;
      nextM:                            op = SEQ_NEXTM;
      default:                          op = SEQ_STEPT;
    endcase
  end

  // nextM from the last M-cycle wraps to M1 and flags an overflow
  always_comb begin
    m_clr  = (op == SEQ_M1) | ((op == SEQ_NEXTM) & m_max);
    m_step = (op == SEQ_NEXTM) & ~m_max;
    t_clr  = (op == SEQ_M1) | (op == SEQ_NEXTM);
    t_step = (op == SEQ_STEPT);
    err_d  = err_q
           | ((op == SEQ_NEXTM) & m_max)
           | ((op == SEQ_STEPT) & t_max);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  onehot_counter #(
    .N (M_CYCLES),
    .W (MW)
  ) u_m (
    .clk    (clk),
    .reset  (reset),
    .clear  (m_clr),
    .step   (m_step),
    .onehot (m_onehot),
    .idx    (m_idx),
    .at_max (m_max)
  );

  onehot_counter #(
    .N (T_STATES),
    .W (TW)
  ) u_t (
    .clk    (clk),
    .reset  (reset),
    .clear  (t_clr),
    .step   (t_step),
    .onehot (t_onehot),
    .idx    (t_idx),
    .at_max (t_max)
  );

  assign last_t  = t_max;
  assign seq_err = err_q;

endmodule

// File: tb/tb_mt_sequencer.sv
// Bench for mt_sequencer: default 6x6 instance against a hand-written table,
// 3x4 instance against a small behavioural model, both via a scoreboard.
module tb_mt_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hold, nm, s1, s1c, ct;

  logic [5:0] m_oh_a, t_oh_a;
  logic [2:0] m_idx_a, t_idx_a;
  logic       last_a, err_a;

  logic [2:0] m_oh_b;
  logic [3:0] t_oh_b;
  logic [1:0] m_idx_b, t_idx_b;
  logic       last_b, err_b;

  mt_sequencer dut_a (
    .clk        (clk),
    .reset      (rst),
    .hold_clk   (hold),
    .nextM      (nm),
    .setM1      (s1),
    .setM1_cond (s1c),
    .cond_true  (ct),
    .m_onehot   (m_oh_a),
    .t_onehot   (t_oh_a),
    .m_idx      (m_idx_a),
    .t_idx      (t_idx_a),
    .last_t     (last_a),
    .seq_err    (err_a)
  );

  mt_sequencer #(
    .M_CYCLES (3),
    .T_STATES (4)
  ) dut_b (
    .clk        (clk),
    .reset      (rst),
    .hold_clk   (hold),
    .nextM      (nm),
    .setM1      (s1),
    .setM1_cond (s1c),
    .cond_true  (ct),
    .m_onehot   (m_oh_b),
    .t_onehot   (t_oh_b),
    .m_idx      (m_idx_b),
    .t_idx      (t_idx_b),
    .last_t     (last_b),
    .seq_err    (err_b)
  );

  typedef struct {
    bit r, h, n, s, sc, c;
    int m, t;
    bit e;
  } vec_t;

  typedef struct {
    int m, t;
    bit e;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  vec_t tbl[$];

  int nvec = 0;
  int nerr = 0;

  int mb, tb;
  bit eb;

  function automatic vec_t v(bit r, bit h, bit n, bit s, bit sc, bit c,
                             int m, int t, bit e);
    vec_t x;
    x.r = r; x.h = h; x.n = n; x.s = s; x.sc = sc; x.c = c;
    x.m = m; x.t = t; x.e = e;
    return x;
  endfunction

  // Behavioural reference for the 3x4 instance
  task automatic model_b(input vec_t x);
    if (x.r) begin
      mb = 0; tb = 0; eb = 0;
    end else if (x.h) begin
    end else if (x.s || (x.sc && !x.c)) begin
      mb = 0; tb = 0;
    end else if (x.n) begin
      tb = 0;
      if (mb == 2) begin mb = 0; eb = 1; end
      else mb = mb + 1;
    end else begin
      if (tb == 3) eb = 1;
      else tb = tb + 1;
    end
  endtask

  task automatic apply(input vec_t x, input int k);
    exp_t ea, eb2;
    exp_t ga, gb;
    @(negedge clk);
    rst = x.r; hold = x.h; nm = x.n; s1 = x.s; s1c = x.sc; ct = x.c;
    ea.m = x.m; ea.t = x.t; ea.e = x.e;
    qa.push_back(ea);
    model_b(x);
    eb2.m = mb; eb2.t = tb; eb2.e = eb;
    qb.push_back(eb2);
    @(posedge clk);
    #1;
    ga = qa.pop_front();
    gb = qb.pop_front();
    nvec++;
    if (int'(m_idx_a) != ga.m || int'(t_idx_a) != ga.t || err_a != ga.e ||
        m_oh_a != (6'd1 << ga.m) || t_oh_a != (6'd1 << ga.t) ||
        last_a != (ga.t == 5)) begin
      nerr++;
      $display("FAIL vec%0d 6x6: got m=%0d t=%0d moh=%b toh=%b last=%b err=%b want m=%0d t=%0d err=%b",
               k, m_idx_a, t_idx_a, m_oh_a, t_oh_a, last_a, err_a,
               ga.m, ga.t, ga.e);
    end
    nvec++;
    if (int'(m_idx_b) != gb.m || int'(t_idx_b) != gb.t || err_b != gb.e ||
        m_oh_b != (3'd1 << gb.m) || t_oh_b != (4'd1 << gb.t) ||
        last_b != (gb.t == 3)) begin
      nerr++;
      $display("FAIL vec%0d 3x4: got m=%0d t=%0d moh=%b toh=%b last=%b err=%b want m=%0d t=%0d err=%b",
               k, m_idx_b, t_idx_b, m_oh_b, t_oh_b, last_b, err_b,
               gb.m, gb.t, gb.e);
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; nm = 1'b0; s1 = 1'b0; s1c = 1'b0; ct = 1'b0;
    mb = 0; tb = 0; eb = 0;

    //           r  h  n  s  sc c   m  t  e
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 5, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 5, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 3, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 2, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 3, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 4, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 5, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Hold stretches the T-state exactly k cycles, then T resumes
    for (int k = 0; k < 4; k++) begin
      apply(v(0, 1, 0, 0, 0, 0, 1, 1, 0), 100 + k);
    end
    apply(v(0, 0, 0, 0, 0, 0, 1, 2, 0), 104);

    // Saturated T with hold asserted raises no error
    apply(v(0, 0, 0, 0, 0, 0, 1, 3, 0), 105);
    apply(v(0, 0, 0, 0, 0, 0, 1, 4, 0), 106);
    apply(v(0, 0, 0, 0, 0, 0, 1, 5, 0), 107);
    apply(v(0, 1, 0, 0, 0, 0, 1, 5, 0), 108);
    apply(v(0, 0, 0, 0, 0, 0, 1, 5, 1), 109);
    apply(v(1, 0, 1, 1, 0, 0, 0, 0, 0), 110);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mt_sequencer.md
# mt_sequencer

Parametrised machine-cycle / T-state sequencer, the next generation of the fixed six-M, six-T sequencer that feeds execute and pin_control in the Z80 core. It tracks the current M-cycle and T-state as both one-hot vectors and binary indices. It adds conditional return to M1, wait-state freezing, saturation with a sticky error flag, and programmable cycle depth. It sits between execute (control requests) and control_pins/pin_control (hold_clk).

## Interface
Parameters:
- M_CYCLES, 6, number of machine cycles per instruction (≥2)
- T_STATES, 6, maximum T-states per machine cycle (≥3)
- MW, $clog2(M_CYCLES), width of binary M index
- TW, $clog2(T_STATES), width of binary T index

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high; one clock; sampled on rising clk
- hold_clk  in  1  wait-state request; freezes sequencer
- nextM  in  1  advance to next M-cycle, T to T1
- setM1  in  1  unconditional return to M1/T1
- setM1_cond  in  1  request return to M1/T1 if cond_true=0
- cond_true  in  1  evaluated flag condition (ss/cc/bz muxed upstream)
- m_onehot  out  M_CYCLES  bit i set = M(i+1)
- t_onehot  out  T_STATES  bit i set = T(i+1)
- m_idx  out  MW  binary M (0 = M1)
- t_idx  out  TW  binary T (0 = T1)
- last_t  out  1  t_idx == T_STATES-1
- seq_err  out  1  sticky overflow error

## Operation
- All outputs registered; reset values: m_onehot = 1, t_onehot = 1, m_idx = 0, t_idx = 0, last_t = 0, seq_err = 0.
- Per rising clk, the first matching rule in this priority applies:
  1. reset: load reset values.
  2. hold_clk=1: all state frozen; nextM, setM1, and setM1_cond are ignored (not queued).
  3. setM1=1, or setM1_cond=1 with cond_true=0: M→M1, T→T1.
  4. nextM=1: if M < M_CYCLES, then M→M+1, T→T1. If M = M_CYCLES, then M→M1, T→T1, seq_err←1.
  5. Otherwise, T advances: T→T+1 if T < T_STATES. At T_STATES, T holds and seq_err←1.
- setM1_cond with cond_true=1 is a no-op and falls through to rules 4 and 5.
- setM1 and nextM asserted together: setM1 wins and no error is raised.
- m_onehot and m_idx are always consistent, as are t_onehot and t_idx. Exactly one bit is set in each one-hot vector.
- seq_err clears only on reset.

## Timing
- One-cycle latency: a request sampled at edge n is visible on outputs after edge n.
- Minimum M-cycle length is 1 clk (nextM every cycle). There is no internal minimum; execute enforces Z80 minimum T counts.
- hold_clk assertion for k cycles stretches the current T-state by exactly k cycles.
- reset asserted mid-cycle takes effect at the next edge regardless of hold_clk.
- last_t is registered together with t_idx; no combinational input-to-output paths.

## Structure
- Shared package seq_pkg holds:
  - default M_CYCLES/T_STATES constants
  - priority encoding enum seq_op_t {SEQ_HOLD, SEQ_M1, SEQ_NEXTM, SEQ_STEPT}
  - one-hot ↔ index helper functions
- One sub-module, onehot_counter (parameter N; inputs clear, step; outputs onehot, idx, at_max). It is instantiated twice: once for M, once for T.
- The top of mt_sequencer holds only the priority decode and the seq_err register.
- Target size is roughly 150–250 RTL lines.

## Test plan
- Release reset, idle 5 clks → t_idx 0,1,2,3,4; m_idx 0; seq_err 0.
- Default params, T to T3 then nextM → m_idx 1, t_idx 0, m_onehot 6'b000010.
- At M2/T2, hold_clk for 3 clks with nextM asserted throughout → state stays M2/T2 for 3 cycles; after release with nextM=1 → M3/T1.
- setM1_cond with cond_true=1 at M2/T3 → M2/T4. Same with cond_true=0 → M1/T1. setM1+nextM together → M1/T1, seq_err 0.
- Boundaries: step T past T6 → t_idx stays 5, seq_err 1. Reset → seq_err 0. nextM at M6 → M1/T1, seq_err 1.
- Re-run scenarios 1–5 with M_CYCLES=3, T_STATES=4 → saturation at t_idx 3, wrap after M3, MW=2, TW=2.
